// File: rtl/spi_loopback_link.sv
// SPI mode-0 master and slave joined by internal nets; the slave echoes the previous byte.
// Build option: define SPI_LSB_FIRST_EN to shift LSB first on both ends (default MSB first).
module spi_loopback_link #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send,
  input  logic [DATA_W-1:0] send_data,
  output logic [DATA_W-1:0] received_data,
  output logic              master_busy,
  output logic              slave_busy,
  output logic              ready
);

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB_FIRST = 1'b1;
`else
  localparam bit LSB_FIRST = 1'b0;
`endif

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BIT_FULL = BC_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  // Master state
  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] received_data_q, received_data_d;
  logic              master_busy_q, master_busy_d;
  logic              ready_q, ready_d;

  // Slave state
  logic              sclk_prev_q, cs_n_prev_q;
  logic [DATA_W-1:0] s_tx_q, s_tx_d;
  logic [DATA_W-1:0] s_rx_shift_q, s_rx_shift_d;
  logic [BC_W-1:0]   s_bit_cnt_q, s_bit_cnt_d;
  logic [DATA_W-1:0] slave_rx_q, slave_rx_d;
  logic              miso_q, miso_d;
  logic              slave_busy_q, slave_busy_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_comb begin
    state_d         = state_q;
    tx_shift_d      = tx_shift_q;
    rx_shift_d      = rx_shift_q;
    bit_cnt_d       = bit_cnt_q;
    ph_cnt_d        = ph_cnt_q;
    sclk_d          = sclk_q;
    cs_n_d          = cs_n_q;
    mosi_d          = mosi_q;
    received_data_d = received_data_q;
    master_busy_d   = master_busy_q;
    ready_d         = ready_q;
    case (state_q)
      IDLE: begin
        if (send) begin
          tx_shift_d    = send_data;
          cs_n_d        = 1'b0;
          master_busy_d = 1'b1;
          mosi_d        = LSB_FIRST ? send_data[0] : send_data[DATA_W-1];
          bit_cnt_d     = '0;
          ph_cnt_d      = '0;
          sclk_d        = 1'b0;
          state_d       = XFER;
        end
      end
      XFER: begin
        if (ph_cnt_q == PH_LAST) begin
          ph_cnt_d = '0;
          sclk_d   = ~sclk_q;
          if (!sclk_q) begin
            rx_shift_d = LSB_FIRST ? {miso_q, rx_shift_q[DATA_W-1:1]}
                                   : {rx_shift_q[DATA_W-2:0], miso_q};
          end else if (bit_cnt_q == BIT_LAST) begin
            // Final falling edge closes the frame instead of driving another bit.
            sclk_d          = 1'b0;
            cs_n_d          = 1'b1;
            received_data_d = rx_shift_q;
            ready_d         = 1'b1;
            state_d         = DONE;
          end else begin
            bit_cnt_d  = bit_cnt_q + BC_W'(1);
            tx_shift_d = LSB_FIRST ? (tx_shift_q >> 1) : (tx_shift_q << 1);
            mosi_d     = LSB_FIRST ? tx_shift_q[1] : tx_shift_q[DATA_W-2];
          end
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      DONE: begin
        master_busy_d = 1'b0;
        ready_d       = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The slave sees the master's registered SCLK/CS_n one clock late.
  assign sclk_rise = sclk_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q & sclk_prev_q;
  assign cs_fall   = ~cs_n_q & cs_n_prev_q;
  assign cs_rise   = cs_n_q & ~cs_n_prev_q;

  always_comb begin
    s_tx_d       = s_tx_q;
    s_rx_shift_d = s_rx_shift_q;
    s_bit_cnt_d  = s_bit_cnt_q;
    slave_rx_d   = slave_rx_q;
    miso_d       = miso_q;
    slave_busy_d = slave_busy_q;
    if (cs_rise) begin
      if (s_bit_cnt_q == BIT_FULL) begin
        slave_rx_d = s_rx_shift_q;
      end
      slave_busy_d = 1'b0;
    end else if (cs_fall) begin
      s_tx_d       = slave_rx_q;
      miso_d       = LSB_FIRST ? slave_rx_q[0] : slave_rx_q[DATA_W-1];
      s_rx_shift_d = '0;
      s_bit_cnt_d  = '0;
      slave_busy_d = 1'b1;
    end else if (!cs_n_q) begin
      if (sclk_rise) begin
        s_rx_shift_d = LSB_FIRST ? {mosi_q, s_rx_shift_q[DATA_W-1:1]}
                                 : {s_rx_shift_q[DATA_W-2:0], mosi_q};
        if (s_bit_cnt_q != BIT_FULL) begin
          s_bit_cnt_d = s_bit_cnt_q + BC_W'(1);
        end
      end
      if (sclk_fall) begin
        s_tx_d = LSB_FIRST ? (s_tx_q >> 1) : (s_tx_q << 1);
        miso_d = LSB_FIRST ? s_tx_q[1] : s_tx_q[DATA_W-2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      tx_shift_q      <= '0;
      rx_shift_q      <= '0;
      bit_cnt_q       <= '0;
      ph_cnt_q        <= '0;
      sclk_q          <= 1'b0;
      cs_n_q          <= 1'b1;
      mosi_q          <= 1'b0;
      received_data_q <= '0;
      master_busy_q   <= 1'b0;
      ready_q         <= 1'b0;
      sclk_prev_q     <= 1'b0;
      cs_n_prev_q     <= 1'b1;
      s_tx_q          <= '0;
      s_rx_shift_q    <= '0;
      s_bit_cnt_q     <= '0;
      slave_rx_q      <= '0;
      miso_q          <= 1'b0;
      slave_busy_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      tx_shift_q      <= tx_shift_d;
      rx_shift_q      <= rx_shift_d;
      bit_cnt_q       <= bit_cnt_d;
      ph_cnt_q        <= ph_cnt_d;
      sclk_q          <= sclk_d;
      cs_n_q          <= cs_n_d;
      mosi_q          <= mosi_d;
      received_data_q <= received_data_d;
      master_busy_q   <= master_busy_d;
      ready_q         <= ready_d;
      sclk_prev_q     <= sclk_q;
      cs_n_prev_q     <= cs_n_q;
      s_tx_q          <= s_tx_d;
      s_rx_shift_q    <= s_rx_shift_d;
      s_bit_cnt_q     <= s_bit_cnt_d;
      slave_rx_q      <= slave_rx_d;
      miso_q          <= miso_d;
      slave_busy_q    <= slave_busy_d;
    end
  end

  assign received_data = received_data_q;
  assign master_busy   = master_busy_q;
  assign slave_busy    = slave_busy_q;
  assign ready         = ready_q;

endmodule

// File: tb/tb_spi_loopback_link.sv
// Randomized bench for spi_loopback_link: reference model is "each reply equals the byte
// sent in the previous transfer since reset", plus frame timing derived from CLK_DIV/DATA_W.
module tb_spi_loopback_link;

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  localparam int XFER_CYC = 2 * 2 * 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] send_data;
  logic [7:0] received_data;
  logic       master_busy;
  logic       slave_busy;
  logic       ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] stim_q[$];

  spi_loopback_link #(.CLK_DIV(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .send(send), .send_data(send_data),
    .received_data(received_data), .master_busy(master_busy),
    .slave_busy(slave_busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends every byte of stim_q with send held high; drops send during the last frame.
  task automatic run_burst();
    int cnt, busy_cnt, rdy_cnt, gap;
    logic [7:0] cur;
    logic [7:0] got;
    @(negedge clk);
    send = 1'b1;
    send_data = stim_q[0];
    for (int i = 0; i < stim_q.size(); i++) begin
      cur = stim_q[i];
      got = 8'h00;
      gap = 0;
      @(negedge clk);
      while (!master_busy && gap < 100) begin
        gap++;
        @(negedge clk);
      end
      check("start", 32'(master_busy), 32'd1);
      if (i > 0) check("idle_gap", 32'(gap + 1), 32'd1);
      check("mosi_first", 32'(dut.mosi_q), 32'(LSB ? cur[0] : cur[7]));
      check("slave_lag", 32'(slave_busy), 32'd0);
      send_data = 8'($urandom);
      if (i == stim_q.size() - 1) send = 1'b0;
      cnt = 1;
      busy_cnt = 1;
      rdy_cnt = 0;
      while (master_busy && cnt < 200) begin
        @(negedge clk);
        cnt++;
        if (master_busy) busy_cnt++;
        if (cnt == 2) check("slave_busy", 32'(slave_busy), 32'd1);
        if (cnt == 20 && i < stim_q.size() - 1) send_data = stim_q[i+1];
        if (ready) begin
          rdy_cnt++;
          if (rdy_cnt == 1) begin
            got = received_data;
            check("latency", 32'(cnt - 1), 32'(XFER_CYC));
            check("rx_data", 32'(received_data), 32'(prev_byte));
          end
        end
      end
      check("busy_end", 32'(master_busy), 32'd0);
      check("busy_len", 32'(busy_cnt), 32'(XFER_CYC + 1));
      check("ready_cnt", 32'(rdy_cnt), 32'd1);
      check("slave_idle", 32'(slave_busy), 32'd0);
      $display("xfer sent=0x%02h received=0x%02h expected=0x%02h busy=%0d", cur, got, prev_byte, busy_cnt);
      prev_byte = cur;
    end
  endtask

  // Starts a frame and resets in the middle of bit 4.
  task automatic run_abort(input logic [7:0] d);
    int cnt;
    @(negedge clk);
    send = 1'b1;
    send_data = d;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!master_busy && cnt < 100);
    check("abort_start", 32'(master_busy), 32'd1);
    send = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rx", 32'(received_data), 32'd0);
    check("abort_mbusy", 32'(master_busy), 32'd0);
    check("abort_sbusy", 32'(slave_busy), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_noready", 32'(ready), 32'd0);
    end
    rst = 1'b0;
    prev_byte = 8'h00;
    $display("abort sent=0x%02h reset mid-frame", d);
  endtask

  initial begin
    rst = 1'b1;
    send = 1'b0;
    send_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rx", 32'(received_data), 32'd0);
    check("rst_mbusy", 32'(master_busy), 32'd0);
    check("rst_sbusy", 32'(slave_busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_mosi", 32'(dut.mosi_q), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    stim_q = '{8'hAB, 8'h5C, 8'hAB};
    run_burst();
    stim_q = '{8'h01, 8'h80, 8'hFF};
    run_burst();
    stim_q = '{8'h3C};
    run_burst();
    repeat (4) @(negedge clk);
    check("idle_after", 32'(master_busy), 32'd0);

    run_abort(8'($urandom));
    stim_q = '{8'h77, 8'h12};
    run_burst();

    for (int r = 0; r < 6; r++) begin
      stim_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) stim_q.push_back(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_burst();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
